// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, coin kinds,
// coin values and the default sizing parameters.
package vending_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    typedef enum logic {
        ONE  = 1'b0,
        FIVE = 1'b1
    } coin_t;

    localparam int COIN_ONE_VALUE      = 1;
    localparam int COIN_FIVE_VALUE     = 5;
    localparam int DEFAULT_MAX_CHANGE  = 10;
    localparam int DEFAULT_ACK_TIMEOUT = 15;

    // Value in units of a given coin kind.
    function automatic logic [3:0] coinValue(coin_t coin);
        return (coin == FIVE) ? 4'(COIN_FIVE_VALUE) : 4'(COIN_ONE_VALUE);
    endfunction

    // Largest coin that fits in the remaining amount, so change never underflows.
    function automatic coin_t pickCoin(logic [3:0] amount);
        return (amount >= 4'(COIN_FIVE_VALUE)) ? FIVE : ONE;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/coin-mechanism/status bundle of the change dispenser.
// The slave side is the dispenser; the master side is the host plus coin mechanism.
interface change_dispenser_if;
    import vending_pkg::*;

    logic       start;
    logic [3:0] change_in;
    logic       coin_ack;
    logic       coin_req;
    coin_t      coin_type;
    logic [3:0] change;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, change_in, coin_ack,
        input  coin_req, coin_type, change, busy, done, error
    );

    modport slave (
        input  start, change_in, coin_ack,
        output coin_req, coin_type, change, busy, done, error
    );

endinterface

// File: rtl/change_dispenser_ack_timer.sv
// Counts unacknowledged coin-request cycles and flags the cycle in which
// the count reaches ACK_TIMEOUT.
module ack_timer
    import vending_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The current counted cycle is the ACK_TIMEOUT-th one when count_q already holds ACK_TIMEOUT-1.
    assign expired = count && (count_q == CNT_W'(ACK_TIMEOUT - 1));

    // Clear wins over count so a fresh request always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount using FIVE and ONE coins, one coin
// per request/acknowledge exchange with the coin mechanism.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int MAX_CHANGE  = DEFAULT_MAX_CHANGE,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    state_t     state_q,    state_d;
    logic [3:0] change_q,   change_d;
    logic       coinReq_q,  coinReq_d;
    coin_t      coinType_q, coinType_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       error_q,    error_d;

    logic startOk;
    logic startBad;
    logic timerClear;
    logic timerCount;
    logic timerExpired;

    assign startOk  = bus.start && (int'(bus.change_in) <= MAX_CHANGE);
    assign startBad = bus.start && (int'(bus.change_in) >  MAX_CHANGE);

    // The timer restarts on every entry to REQ and only ticks while REQ waits for an ack.
    assign timerClear = (state_d == REQ) && (state_q != REQ);
    assign timerCount = (state_q == REQ) && !bus.coin_ack;

    ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timerClear),
        .count   (timerCount),
        .expired (timerExpired)
    );

    // Next state, next remaining amount, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        change_d = change_q;

        case (state_q)
            IDLE: begin
                if (startOk) begin
                    change_d = bus.change_in;
                    state_d  = (bus.change_in == 4'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.coin_ack) begin
                    change_d = change_q - coinValue(pickCoin(change_q));
                    state_d  = GAP;
                end else if (timerExpired) begin
                    state_d = FAULT;
                end
            end
            GAP: begin
                if (!bus.coin_ack) begin
                    state_d = (change_q != 4'd0) ? REQ : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        coinReq_d  = (state_d == REQ);
        coinType_d = (state_d == REQ) ? pickCoin(change_d) : ONE;
        busy_d     = (state_d == REQ) || (state_d == GAP);
        done_d     = (state_d == DONE);
        error_d    = ((state_q == IDLE) && startBad) || (state_d == FAULT);
    end

    // State and output registers; reset returns everything to an idle, empty dispenser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            change_q   <= 4'd0;
            coinReq_q  <= 1'b0;
            coinType_q <= ONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            change_q   <= change_d;
            coinReq_q  <= coinReq_d;
            coinType_q <= coinType_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.coin_req  = coinReq_q;
    assign bus.coin_type = coinType_q;
    assign bus.change    = change_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coin,
// done and error events; a monitor pops and compares them as they appear.
module tb_change_dispenser;
    import vending_pkg::*;

    typedef enum int {EV_COIN, EV_DONE, EV_ERR} evKind_t;

    typedef struct {
        evKind_t kind;
        coin_t   coin;
        int      amount;
    } expEv_t;

    logic clk = 1'b0;
    logic reset;

    change_dispenser_if dif();

    change_dispenser #(
        .MAX_CHANGE  (10),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int     checks        = 0;
    int     errors        = 0;
    expEv_t sbQueue[$];
    int     coinReqCount  = 0;
    int     doneCount     = 0;
    int     reqHighCycles = 0;
    bit     ackEnable     = 1'b0;
    int     ackDelay      = 2;
    bit     lateAck       = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void pushExpect(input evKind_t kind, input coin_t coin, input int amount);
        expEv_t e;
        e.kind   = kind;
        e.coin   = coin;
        e.amount = amount;
        sbQueue.push_back(e);
    endfunction

    task automatic popCheck(input evKind_t kind);
        expEv_t ev;
        if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected %s event: got change %0d, expected no event", kind.name(), dif.change);
            return;
        end
        ev = sbQueue.pop_front();
        checkOutput("eventKind", kind, ev.kind);
        checkOutput("eventChange", dif.change, ev.amount);
        case (kind)
            EV_COIN: begin
                checkOutput("coinType", dif.coin_type, ev.coin);
                checkOutput("coinBusy", dif.busy, 1);
            end
            EV_DONE: begin
                checkOutput("doneBusy", dif.busy, 0);
            end
            default: begin
                checkOutput("errCoinReq", dif.coin_req, 0);
                checkOutput("errBusy", dif.busy, 0);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [3:0] amount);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.change_in = amount;
        @(negedge clk);
        dif.start     = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cyc = 0;
        while ((sbQueue.size() != 0 || dif.busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "Drained"}, (sbQueue.size() == 0 && !dif.busy), 1);
        sbQueue.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "CoinReq"}, dif.coin_req, 0);
        checkOutput({name, "CoinType"}, dif.coin_type, ONE);
        checkOutput({name, "Change"}, dif.change, 0);
        checkOutput({name, "Busy"}, dif.busy, 0);
        checkOutput({name, "Done"}, dif.done, 0);
        checkOutput({name, "Error"}, dif.error, 0);
    endtask

    // Monitor: turns DUT output activity into events and checks them against the queue.
    initial begin
        logic prevReq = 1'b0;
        logic prevErr = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.coin_req) reqHighCycles++;
            if (dif.coin_req && !prevReq) begin
                coinReqCount++;
                popCheck(EV_COIN);
            end
            if (dif.done) begin
                doneCount++;
                popCheck(EV_DONE);
            end
            if (dif.error && !prevErr) popCheck(EV_ERR);
            prevReq = dif.coin_req;
            prevErr = dif.error;
        end
    end

    // Coin mechanism model: acknowledges each request ackDelay cycles after it appears.
    initial begin
        int age = 0;
        dif.coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.coin_ack) begin
                dif.coin_ack = 1'b0;
            end else if (lateAck) begin
                dif.coin_ack = 1'b1;
                lateAck      = 1'b0;
            end else if (ackEnable && dif.coin_req) begin
                age++;
                if (age >= ackDelay) begin
                    dif.coin_ack = 1'b1;
                    age          = 0;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Directed scenarios.
    initial begin
        int c0;
        int d0;
        int r0;
        int cyc;

        reset         = 1'b1;
        dif.start     = 1'b0;
        dif.change_in = 4'd0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        reset = 1'b0;

        ackEnable = 1'b1;
        ackDelay  = 2;

        $display("[TB] 7 units: FIVE, ONE, ONE");
        pushExpect(EV_COIN, FIVE, 7);
        pushExpect(EV_COIN, ONE, 2);
        pushExpect(EV_COIN, ONE, 1);
        pushExpect(EV_DONE, ONE, 0);
        c0 = coinReqCount;
        d0 = doneCount;
        applyStimulus(4'd7);
        waitDrain("seven");
        checkOutput("sevenReqPulses", coinReqCount - c0, 3);
        checkOutput("sevenDonePulses", doneCount - d0, 1);

        $display("[TB] 10 units: FIVE, FIVE");
        pushExpect(EV_COIN, FIVE, 10);
        pushExpect(EV_COIN, FIVE, 5);
        pushExpect(EV_DONE, ONE, 0);
        c0 = coinReqCount;
        d0 = doneCount;
        applyStimulus(4'd10);
        waitDrain("ten");
        checkOutput("tenReqPulses", coinReqCount - c0, 2);
        checkOutput("tenDonePulses", doneCount - d0, 1);

        $display("[TB] 0 units: done without coins");
        pushExpect(EV_DONE, ONE, 0);
        c0 = coinReqCount;
        d0 = doneCount;
        applyStimulus(4'd0);
        repeat (2) @(negedge clk);
        checkOutput("zeroDoneSeen", doneCount - d0, 1);
        checkOutput("zeroReqPulses", coinReqCount - c0, 0);
        waitDrain("zero");

        $display("[TB] 12 units rejected, then 3 units");
        pushExpect(EV_ERR, ONE, 0);
        pushExpect(EV_COIN, ONE, 3);
        pushExpect(EV_COIN, ONE, 2);
        pushExpect(EV_COIN, ONE, 1);
        pushExpect(EV_DONE, ONE, 0);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.change_in = 4'd12;
        @(negedge clk);
        dif.change_in = 4'd3;
        @(negedge clk);
        dif.start     = 1'b0;
        checkOutput("errOneCycle", dif.error, 0);
        waitDrain("badThenThree");

        $display("[TB] 6 units with no ack: timeout fault");
        ackEnable = 1'b0;
        pushExpect(EV_COIN, FIVE, 6);
        pushExpect(EV_ERR, ONE, 6);
        r0 = reqHighCycles;
        applyStimulus(4'd6);
        cyc = 0;
        while (!dif.error && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("faultReached", dif.error, 1);
        checkOutput("faultReqCycles", reqHighCycles - r0, 15);
        checkOutput("faultCoinReq", dif.coin_req, 0);
        checkOutput("faultBusy", dif.busy, 0);
        checkOutput("faultChange", dif.change, 6);
        applyStimulus(4'd3);
        repeat (3) @(negedge clk);
        checkOutput("faultStartIgnoredErr", dif.error, 1);
        checkOutput("faultStartIgnoredChange", dif.change, 6);
        checkOutput("faultStartIgnoredReq", dif.coin_req, 0);
        checkOutput("faultEventsSeen", sbQueue.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetOutputs("faultReset");
        @(negedge clk);
        reset = 1'b0;
        sbQueue.delete();

        $display("[TB] 9 units with reset during second request");
        ackEnable = 1'b1;
        pushExpect(EV_COIN, FIVE, 9);
        pushExpect(EV_COIN, ONE, 4);
        applyStimulus(4'd9);
        cyc = 0;
        while (!(dif.coin_req && dif.change == 4'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midSecondReq", (dif.coin_req && dif.change == 4'd4), 1);
        ackEnable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("midReset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        c0 = coinReqCount;
        lateAck = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("lateAckReqPulses", coinReqCount - c0, 0);
        checkOutput("lateAckBusy", dif.busy, 0);
        checkOutput("lateAckChange", dif.change, 0);
        checkOutput("lateAckQueue", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
